// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types, field positions and bubble value for the fetch stage
package ifetch_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    typedef logic [0:31] pc_t;
    typedef logic [0:31] word_t;
    localparam int OP_LO  = 0;
    localparam int OP_HI  = 5;
    localparam int RS1_LO = 6;
    localparam int RS1_HI = 10;
    localparam int RS2_LO = 11;
    localparam int RS2_HI = 15;
    localparam int RD_LO  = 16;
    localparam int RD_HI  = 20;
    localparam int FN_LO  = 26;
    localparam int FN_HI  = 31;
    localparam int IM_LO  = 16;
    localparam int IM_HI  = 31;
    localparam word_t NOP = '0;
    function automatic pc_t align(input pc_t p);
        return p & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory request/ack bus
interface ifetch_if;
    import ifetch_pkg::*;
    logic  IMemReq;
    pc_t   IMemAddr;
    logic  IMemAck;
    word_t IMemData;
    modport master(output IMemReq, IMemAddr, input IMemAck, IMemData);
    modport slave(input IMemReq, IMemAddr, output IMemAck, IMemData);
endinterface

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: one-entry skid buffer holding a word and its PC+4 behind Stall
module ifetch_buffer
    import ifetch_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t d_word,
    input  pc_t   d_pc4,
    output word_t q_word,
    output pc_t   q_pc4,
    output logic  full
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            full   <= 1'b0;
            q_word <= NOP;
            q_pc4  <= '0;
        end else if (clear || drain) begin
            full <= 1'b0;
        end else if (load) begin
            full   <= 1'b1;
            q_word <= d_word;
            q_pc4  <= d_pc4;
        end
endmodule

// File: rtl/ifetch.sv
// ifetch: fetch FSM and PC feeding registered decode fields; redirects drain in-flight words.
// Define IFETCH_PERF_CNT_EN to add FetchCount/FlushCount outputs.
module ifetch
    import ifetch_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        RedirectValid,
    input  pc_t         RedirectPC,
    ifetch_if.master    mem,
    output logic [5:0]  NextOpCode,
    output logic [5:0]  NextFunct,
    output logic [4:0]  NextRs1,
    output logic [4:0]  NextRs2,
    output logic [4:0]  NextRd,
    output logic [15:0] NextImmd,
    output pc_t         NextPCPlusFour,
    output logic        NextValid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);
    state_t state;
    pc_t    pc, target, pc4, b_pc4;
    word_t  word, b_word;
    logic   active, ack, b_full, b_load, b_drain;

    // A full buffer means HOLD, the only state without an outstanding request
    assign mem.IMemReq  = active && !b_full;
    assign mem.IMemAddr = pc;
    assign ack          = mem.IMemAck && mem.IMemReq;
    assign pc4          = pc + 32'd4;
    assign b_load       = !RedirectValid && state == FETCH && ack && Stall;
    assign b_drain      = !RedirectValid && b_full && !Stall;

    assign NextOpCode = word[OP_LO:OP_HI];
    assign NextRs1    = word[RS1_LO:RS1_HI];
    assign NextRs2    = word[RS2_LO:RS2_HI];
    assign NextRd     = word[RD_LO:RD_HI];
    assign NextFunct  = word[FN_LO:FN_HI];
    assign NextImmd   = word[IM_LO:IM_HI];

    ifetch_buffer u_buf (
        .clk(clk), .reset(reset), .load(b_load), .drain(b_drain), .clear(RedirectValid),
        .d_word(mem.IMemData), .d_pc4(pc4), .q_word(b_word), .q_pc4(b_pc4), .full(b_full)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state          <= FETCH;
            pc             <= RESET_PC;
            target         <= RESET_PC;
            word           <= NOP;
            NextPCPlusFour <= '0;
            NextValid      <= 1'b0;
            active         <= 1'b0;
        end else begin
            active <= 1'b1;
            if (RedirectValid) begin
                word           <= NOP;
                NextPCPlusFour <= '0;
                NextValid      <= 1'b0;
                // An unacked request cannot be withdrawn: keep its address and drain it
                if (mem.IMemReq && !ack) begin
                    state  <= DRAIN;
                    target <= align(RedirectPC);
                end else begin
                    state <= FETCH;
                    pc    <= align(RedirectPC);
                end
            end else if (state == FETCH) begin
                if (ack && Stall) state <= HOLD;
                else if (!Stall) begin
                    word           <= ack ? mem.IMemData : NOP;
                    NextPCPlusFour <= ack ? pc4 : '0;
                    NextValid      <= ack;
                    pc             <= ack ? pc4 : pc;
                end
            end else if (state == HOLD) begin
                if (!Stall) begin
                    word           <= b_word;
                    NextPCPlusFour <= b_pc4;
                    NextValid      <= 1'b1;
                    pc             <= pc4;
                    state          <= FETCH;
                end
            end else if (ack) begin
                pc    <= target;
                state <= FETCH;
            end
        end

`ifdef IFETCH_PERF_CNT_EN
    logic fetched, flushed;
    assign fetched = !RedirectValid && !Stall && (b_full || (state == FETCH && ack));
    assign flushed = (state == DRAIN && ack) || (RedirectValid && (b_full || ack));
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            FetchCount <= FetchCount + {31'b0, fetched};
            FlushCount <= FlushCount + {31'b0, flushed};
        end
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: randomized bench for ifetch against a transaction-level fetch model
module tb_ifetch;
    import ifetch_pkg::*;
    logic clk = 1'b0, reset = 1'b0, Stall = 1'b0, RedirectValid = 1'b0;
    pc_t RedirectPC = '0;
    logic [5:0] NextOpCode, NextFunct;
    logic [4:0] NextRs1, NextRs2, NextRd;
    logic [15:0] NextImmd;
    pc_t NextPCPlusFour;
    logic NextValid;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] FetchCount, FlushCount;
`endif
    int errors = 0, checks = 0;
    pc_t m_fa, m_tgt, m_op4;
    word_t m_hw, m_ow;
    logic m_stale, m_hv, m_started, m_ov;
    int unsigned m_fc, m_flc;
    logic ovr_en = 1'b0;
    word_t ovr = '0;

    ifetch_if mem();

    ifetch #(.RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .RedirectValid(RedirectValid),
        .RedirectPC(RedirectPC), .mem(mem),
`ifdef IFETCH_PERF_CNT_EN
        .FetchCount(FetchCount), .FlushCount(FlushCount),
`endif
        .NextOpCode(NextOpCode), .NextFunct(NextFunct), .NextRs1(NextRs1), .NextRs2(NextRs2),
        .NextRd(NextRd), .NextImmd(NextImmd), .NextPCPlusFour(NextPCPlusFour), .NextValid(NextValid)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic word_t mem_word(input pc_t a);
        return a * 32'h9E37_79B1 ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        m_fa = '0; m_tgt = '0; m_op4 = '0; m_hw = '0; m_ow = '0;
        m_stale = 1'b0; m_hv = 1'b0; m_started = 1'b0; m_ov = 1'b0;
        m_fc = 0; m_flc = 0;
    endtask

    task automatic deliver(input word_t w);
        m_ow = w; m_op4 = m_fa + 32'd4; m_ov = 1'b1; m_fa = m_fa + 32'd4; m_fc++;
    endtask

    task automatic bubble();
        m_ow = '0; m_op4 = '0; m_ov = 1'b0;
    endtask

    task automatic check_all();
        check("req", 32'(mem.IMemReq), 32'(m_started && !m_hv));
        if (m_started && !m_hv) check("addr", mem.IMemAddr, m_fa);
        check("opcode", 32'(NextOpCode), 32'(m_ow[0:5]));
        check("rs1", 32'(NextRs1), 32'(m_ow[6:10]));
        check("rs2", 32'(NextRs2), 32'(m_ow[11:15]));
        check("rd", 32'(NextRd), 32'(m_ow[16:20]));
        check("funct", 32'(NextFunct), 32'(m_ow[26:31]));
        check("immd", 32'(NextImmd), 32'(m_ow[16:31]));
        check("pc4", NextPCPlusFour, m_op4);
        check("valid", 32'(NextValid), 32'(m_ov));
`ifdef IFETCH_PERF_CNT_EN
        check("fetch_cnt", FetchCount, m_fc);
        check("flush_cnt", FlushCount, m_flc);
`endif
    endtask

    // Called at a falling edge: check, drive one cycle of inputs, advance the model past the rising edge
    task automatic step(input logic s, input logic rv, input pc_t rpc, input int ack_pct);
        logic req, a;
        word_t d;
        check_all();
        req = m_started && !m_hv;
        a = req && (int'($urandom_range(99)) < ack_pct);
        d = ovr_en ? ovr : mem_word(m_fa);
        Stall = s; RedirectValid = rv; RedirectPC = rpc;
        mem.IMemAck = a; mem.IMemData = d;
        if (rv) begin
            bubble();
            m_flc += (m_hv || a) ? 1 : 0;
            m_hv = 1'b0;
            if (req && !a) begin
                m_stale = 1'b1; m_tgt = (rpc >> 2) << 2;
            end else begin
                m_stale = 1'b0; m_fa = (rpc >> 2) << 2;
            end
        end else if (m_stale) begin
            if (a) begin
                m_stale = 1'b0; m_fa = m_tgt; m_flc++;
            end
        end else if (m_hv) begin
            if (!s) begin
                m_hv = 1'b0; deliver(m_hw);
            end
        end else if (a && s) begin
            m_hv = 1'b1; m_hw = d;
        end else if (a) deliver(d);
        else if (!s) bubble();
        m_started = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mem.IMemAck = 1'b0;
        mem.IMemData = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(1'b0, 1'b0, '0, 100);
        check("seq_pc4", NextPCPlusFour, 32'd12);
        check("seq_addr", mem.IMemAddr, 32'd12);

        ovr_en = 1'b1; ovr = 32'h2041_0005;
        step(1'b1, 1'b0, '0, 100);
        ovr_en = 1'b0;
        check("hold_req", 32'(mem.IMemReq), 32'd0);
        check("hold_pc4", NextPCPlusFour, 32'd12);
        step(1'b1, 1'b0, '0, 0);
        step(1'b1, 1'b0, '0, 0);
        check("hold_req3", 32'(mem.IMemReq), 32'd0);
        step(1'b0, 1'b0, '0, 0);
        check("skid_op", 32'(NextOpCode), 32'h08);
        check("skid_rs1", 32'(NextRs1), 32'd2);
        check("skid_rs2", 32'(NextRs2), 32'd1);
        check("skid_immd", 32'(NextImmd), 32'h0005);
        check("skid_valid", 32'(NextValid), 32'd1);
        check("skid_pc4", NextPCPlusFour, 32'd16);

        step(1'b0, 1'b1, 32'h40, 0);
        step(1'b0, 1'b0, '0, 100);
        check("drn_addr0", mem.IMemAddr, 32'h40);
        step(1'b0, 1'b1, 32'h100, 0);
        check("drn_addr1", mem.IMemAddr, 32'h40);
        check("drn_valid1", 32'(NextValid), 32'd0);
        step(1'b0, 1'b0, '0, 0);
        check("drn_addr2", mem.IMemAddr, 32'h40);
        step(1'b0, 1'b0, '0, 100);
        check("drn_addr3", mem.IMemAddr, 32'h100);
        check("drn_valid3", 32'(NextValid), 32'd0);

        step(1'b1, 1'b1, 32'h200, 100);
        check("rs_valid", 32'(NextValid), 32'd0);
        check("rs_req", 32'(mem.IMemReq), 32'd1);
        check("rs_addr", mem.IMemAddr, 32'h200);

        step(1'b0, 1'b1, 32'hFFFF_FFFF, 100);
        check("wrap_start", mem.IMemAddr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, '0, 100);
        check("wrap_pc4", NextPCPlusFour, 32'h0);
        check("wrap_addr", mem.IMemAddr, 32'h0);
        check("wrap_valid", 32'(NextValid), 32'd1);

        repeat (500) step($urandom_range(9) < 3, $urandom_range(99) < 8, $urandom, 60);

        step(1'b0, 1'b0, '0, 0);
        step(1'b0, 1'b1, 32'h300, 0);
        check("pre_rst_req", 32'(mem.IMemReq), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_req", 32'(mem.IMemReq), 32'd0);
        check("rst_valid", 32'(NextValid), 32'd0);
        check("rst_pc4", NextPCPlusFour, 32'd0);
        check("rst_op", 32'(NextOpCode), 32'd0);
        check("rst_immd", 32'(NextImmd), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_fcnt", FetchCount, 32'd0);
        check("rst_flcnt", FlushCount, 32'd0);
`endif
        model_reset();
        Stall = 1'b0; RedirectValid = 1'b0; mem.IMemAck = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step(1'b0, 1'b0, '0, 100);
        check("rst_addr", mem.IMemAddr, 32'h0);
        check("rst_req1", 32'(mem.IMemReq), 32'd1);
        repeat (3) step(1'b0, 1'b0, '0, 100);
        check_all();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC fetched first after reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces the reset state immediately.
REQ-004 Stall  in  1  hazard hold from Decode; 1 holds the decode-facing outputs.
REQ-005 RedirectValid  in  1, RedirectPC  in  32 [0:31]  taken branch/jump target; RedirectPC bits [30:31] treated as 00.
REQ-006 IMemReq  out  1, IMemAddr  out  32 [0:31]  instruction-memory request and word address.
REQ-007 IMemAck  in  1, IMemData  in  32 [0:31]  request accepted; data valid in the ack cycle.
REQ-008 NextOpCode out 6, NextFunct out 6, NextRs1/NextRs2/NextRd out 5 each, NextImmd out 16, NextPCPlusFour out 32, NextValid out 1  registered decode-facing fields.

Function
REQ-009 Field slicing: OpCode=IMemData[0:5], Rs1=[6:10], Rs2=[11:15], Rd=[16:20], Funct=[26:31], Immd=[16:31].
REQ-010 FSM states: FETCH (request outstanding), HOLD (word buffered behind Stall), DRAIN (discard in-flight word after redirect).
REQ-011 FETCH: IMemReq=1, IMemAddr=PC; IMemAddr held stable until IMemAck.
REQ-012 FETCH, IMemAck=1, Stall=0: outputs load the fields, NextPCPlusFour=PC+4, NextValid=1; PC<=PC+4; remain in FETCH (back-to-back fetch, throughput 1/cycle with zero-wait memory).
REQ-013 FETCH, IMemAck=1, Stall=1: word and PC+4 captured in the one-entry buffer; go to HOLD; outputs unchanged.
REQ-014 FETCH, IMemAck=0, Stall=0: outputs become a bubble (all fields 0, NextValid=0).
REQ-015 Stall=1 in any state without redirect: all decode-facing outputs hold their value.
REQ-016 HOLD: IMemReq=0; when Stall=0 the buffer moves to the outputs, PC<=PC+4, go to FETCH.
REQ-017 RedirectValid=1 has priority over Stall and IMemAck: outputs become a bubble, buffer cleared, PC<=RedirectPC.
REQ-018 Redirect in FETCH with IMemAck=1 in the same cycle: returned word discarded; next state FETCH at RedirectPC.
REQ-019 Redirect in FETCH with IMemAck=0: go to DRAIN; IMemReq stays 1 at the old address until ack; acked word discarded; then FETCH at the saved target.
REQ-020 Second redirect while in DRAIN: saved target overwritten by the latest RedirectPC.
REQ-021 PC arithmetic modulo 2^32: PC=32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-022 Latency: instruction visible on Next* one cycle after its IMemAck edge.

Reset
REQ-023 While reset=0: state=FETCH, PC=RESET_PC, buffer empty, all Next* outputs 0, NextValid=0.
REQ-024 IMemReq=0 while reset=0; first request issued in the first cycle after reset deasserts.
REQ-025 Reset asserted mid-request abandons the request; any later IMemAck from it is not expected.

Configuration
REQ-026 Macro IFETCH_PERF_CNT_EN defined: adds outputs FetchCount and FlushCount (32 bits each), counting delivered instructions (NextValid loads) and discarded words (REQ-018/019/017 buffer clears); both reset to 0 and wrap.
REQ-027 Macro undefined: counters and their ports absent; all other behaviour identical.

Structure
REQ-028 Package ifetch_pkg holds the state encoding, field bit-position constants, NOP/bubble value, and the 32-bit PC type.
REQ-029 The one-entry skid buffer is sub-module ifetch_buffer (load, drain, clear, full flag); the FSM and PC stay in ifetch.

Verification
REQ-030 Zero-wait memory, no stall, RESET_PC=0: IMemAddr 0,4,8,... on consecutive cycles; NextPCPlusFour 4,8,12 one cycle after each ack.
REQ-031 Ack with Stall=1 for 3 cycles, IMemData=32'h2041_0005: outputs frozen, IMemReq=0 in HOLD; after Stall drops NextOpCode=6'h08, NextRs1=2, NextRs2=1, NextImmd=16'h0005, NextValid=1.
REQ-032 Redirect to 32'h0000_0100 while request to 32'h40 waits 2 cycles for ack: IMemAddr stays 32'h40 until ack, word discarded, next IMemAddr=32'h100, NextValid=0 until then.
REQ-033 Redirect and IMemAck in the same cycle with Stall=1: bubble out, next IMemAddr=RedirectPC, no HOLD entry.
REQ-034 PC=32'hFFFF_FFFC acked: next IMemAddr=32'h0, NextPCPlusFour=32'h0.
REQ-035 reset pulsed low mid-DRAIN: all outputs 0 immediately; first post-reset IMemAddr=RESET_PC; with IFETCH_PERF_CNT_EN both counters read 0.
